// File: rtl/asyncarm_pkg.sv
// Shared types for the decode <-> register-bank operand-fetch path.
// Register index/word types and the register-bank read FSM encoding.
package asyncarm_pkg;

    localparam int NUM_ARCH_REGS = 16;
    localparam int WORD_W        = 32;

    typedef logic [3:0]        reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_CAPTURE,
        RB_RESPOND
    } rb_state_t;

endpackage

// File: rtl/toggle_sync.sv
// Level synchroniser for a two-phase request toggle: SYNC_STAGES flops, output is the synced level.
// Latency SYNC_STAGES clk edges; no backpressure (pure level follower).
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tog_i,
    output logic tog_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
        end
    end

    assign tog_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reg_bank_responder.sv
// Register bank answering two-phase read requests from decode and two-phase write-backs.
// Read: toggle -> readyOutRB high after SYNC_STAGES+3 edges; a toggle before ready returns is not queued.
import asyncarm_pkg::*;

module reg_bank_responder #(
    parameter int NUM_REGS    = NUM_ARCH_REGS,
    parameter int DATA_W      = WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              triggerInRB,
    input  logic [31:0]       addrInRB,
    output logic [DATA_W-1:0] dataOutRB,
    output logic              readyOutRB,
    input  logic              wrTriggerIn,
    input  logic [3:0]        wrAddrIn,
    input  logic [DATA_W-1:0] wrDataIn,
    output logic              wrAckOut
);

    logic              rd_sync;
    logic              wr_sync;
    logic              wr_commit;
    logic              unused_addr_bits;

    rb_state_t         state_q, state_d;
    logic              ready_q, ready_d;
    logic              rd_phase_q, rd_phase_d;
    logic              wr_phase_q;
    reg_idx_t          idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clk   (clk),
        .reset (reset),
        .tog_i (triggerInRB),
        .tog_o (rd_sync)
    );

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk   (clk),
        .reset (reset),
        .tog_i (wrTriggerIn),
        .tog_o (wr_sync)
    );

    assign unused_addr_bits = ^addrInRB[31:4];
    assign wr_commit        = (wr_sync != wr_phase_q);

    // Phase compare against the raw toggle kills ready the moment a new request is raised.
    assign readyOutRB = ready_q & (triggerInRB == rd_phase_q);
    assign dataOutRB  = data_q;
    assign wrAckOut   = wr_phase_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        rd_phase_d = rd_phase_q;
        idx_d      = idx_q;
        data_d     = data_q;
        case (state_q)
            RB_IDLE: begin
                if (rd_sync != rd_phase_q) begin
                    state_d = RB_CAPTURE;
                    ready_d = 1'b0;
                end
            end
            RB_CAPTURE: begin
                idx_d   = addrInRB[3:0];
                state_d = RB_RESPOND;
            end
            RB_RESPOND: begin
                // Write-first: a commit landing on this edge to the same register wins.
                if (wr_commit && (wrAddrIn == idx_q)) begin
                    data_d = wrDataIn;
                end else begin
                    data_d = regs_q[idx_q];
                end
                rd_phase_d = ~rd_phase_q;
                ready_d    = 1'b1;
                state_d    = RB_IDLE;
            end
            default: begin
                state_d = RB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RB_IDLE;
            ready_q    <= 1'b1;
            rd_phase_q <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rd_phase_q <= rd_phase_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_phase_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            wr_phase_q       <= ~wr_phase_q;
            regs_q[wrAddrIn] <= wrDataIn;
        end
    end

endmodule

// File: tb/tb_reg_bank_responder.sv
// Directed plus randomized bench for reg_bank_responder against an array model of the register file.
module tb_reg_bank_responder;

    localparam int SYNC_STAGES = 2;
    localparam int RD_LAT      = SYNC_STAGES + 3;
    localparam int WR_LAT      = SYNC_STAGES + 1;
    localparam int BUDGET      = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        triggerInRB = 1'b0;
    logic [31:0] addrInRB = '0;
    logic [31:0] dataOutRB;
    logic        readyOutRB;
    logic        wrTriggerIn = 1'b0;
    logic [3:0]  wrAddrIn = '0;
    logic [31:0] wrDataIn = '0;
    logic        wrAckOut;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [16];
    logic        ack_model = 1'b0;
    int          ack_toggles = 0;
    logic        ack_prev = 1'b0;

    reg_bank_responder #(.NUM_REGS(16), .DATA_W(32), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .triggerInRB (triggerInRB),
        .addrInRB    (addrInRB),
        .dataOutRB   (dataOutRB),
        .readyOutRB  (readyOutRB),
        .wrTriggerIn (wrTriggerIn),
        .wrAddrIn    (wrAddrIn),
        .wrDataIn    (wrDataIn),
        .wrAckOut    (wrAckOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrAckOut !== ack_prev) ack_toggles <= ack_toggles + 1;
        ack_prev <= wrAckOut;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        ack_model = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [31:0] val, input string tag);
        int n;
        wrAddrIn    = idx;
        wrDataIn    = val;
        wrTriggerIn = ~wrTriggerIn;
        ack_model   = ~ack_model;
        n = 0;
        while (n < BUDGET) begin
            tick();
            n++;
            if (wrAckOut === ack_model) break;
        end
        check({tag, "_wr_lat"}, n, WR_LAT);
        model[idx] = val;
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        int n;
        addrInRB = addr;
        #1;
        triggerInRB = ~triggerInRB;
        #1;
        check({tag, "_rdy_drop"}, {31'b0, readyOutRB}, 32'd0);
        n = 0;
        while (n < BUDGET) begin
            tick();
            n++;
            if (readyOutRB === 1'b1) break;
        end
        check({tag, "_rd_lat"}, n, RD_LAT);
        check({tag, "_rd_data"}, dataOutRB, model[addr[3:0]]);
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] a;
        logic [31:0] d;

        clear_model();
        repeat (3) tick();
        check("rst_data", dataOutRB, 32'd0);
        check("rst_ready", {31'b0, readyOutRB}, 32'd1);
        check("rst_ack", {31'b0, wrAckOut}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: preload and read back
        do_write(4'd3, 32'hDEADBEEF, "t1");
        do_read(32'd3, "t1");

        // 2: upper address bits ignored
        do_read(32'h0000_0013, "t2");

        // 3: write commit on the RESPOND edge, same register
        addrInRB = 32'd5;
        #1;
        triggerInRB = ~triggerInRB;
        tick();
        tick();
        wrAddrIn    = 4'd5;
        wrDataIn    = 32'h12345678;
        wrTriggerIn = ~wrTriggerIn;
        ack_model   = ~ack_model;
        n = 2;
        while (n < BUDGET) begin
            tick();
            n++;
            if (n == RD_LAT - 1) check("t3_ack_early", {31'b0, wrAckOut}, {31'b0, ~ack_model});
            if (readyOutRB === 1'b1) break;
        end
        model[5] = 32'h12345678;
        check("t3_rd_lat", n, RD_LAT);
        check("t3_bypass", dataOutRB, 32'h12345678);
        check("t3_ack", {31'b0, wrAckOut}, {31'b0, ack_model});

        // 4: back-to-back reads
        do_write(4'd1, 32'd1, "t4a");
        do_write(4'd2, 32'd2, "t4b");
        do_read(32'd1, "t4r1");
        do_read(32'd2, "t4r2");

        // 5: reset while in CAPTURE with trigger high
        reset = 1'b1;
        triggerInRB = 1'b0;
        wrTriggerIn = 1'b0;
        tick();
        reset = 1'b0;
        clear_model();
        tick();
        addrInRB = 32'd3;
        triggerInRB = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        reset = 1'b1;
        #1;
        check("t5_rst_data", dataOutRB, 32'd0);
        check("t5_rst_ack", {31'b0, wrAckOut}, 32'd0);
        check("t5_rst_ready", {31'b0, readyOutRB}, 32'd0);
        tick();
        reset = 1'b0;
        n = 0;
        while (n < BUDGET) begin
            tick();
            n++;
            if (readyOutRB === 1'b1) break;
        end
        check("t5_rd_lat", n, RD_LAT);
        check("t5_rd_data", dataOutRB, 32'd0);

        // 6: ten writes then ten reads
        tick();
        base = ack_toggles;
        for (int i = 0; i < 10; i++) do_write(i[3:0], i * 32'h11, "t6w");
        for (int i = 0; i < 10; i++) do_read(i, "t6r");
        tick();
        check("t6_ack_toggles", ack_toggles - base, 32'd10);

        // randomized mix of writes and reads with junk upper address bits
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) do_write(a[3:0], d, "rnd");
            else do_read(a, "rnd");
        end
        for (int i = 0; i < 16; i++) do_read({$urandom_range(0, 255), i[3:0]}, "sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
